// File: rtl/aes_pkg.sv
// Shared AES types, sizes and the inverse S-box table used by the decryption datapath.
package aes_pkg;

  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned STATE_W   = 128;

  typedef logic [WORD_W-1:0]  aes_word_t;
  typedef logic [STATE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {IDLE, SUB, DONE} inv_sub_state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sbox.sv
// Single-byte AES inverse S-box, pure combinational table lookup.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/inv_substitute.sv
// Inverse SubBytes stage: one 32-bit word per cycle through four inverse S-boxes,
// full 128-bit result presented after four cycles with a valid flag.
module inv_substitute
  import aes_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned WORD_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [STATE_W-1:0] data_in,
  output logic               ready,
  output logic               out_valid,
  output logic [STATE_W-1:0] data_out
);

  localparam int unsigned BUF_W = (NUM_WORDS - 1) * WORD_W;
  localparam int unsigned CNT_W = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

  inv_sub_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  aes_state_t       out_q, out_d;

  aes_word_t sub_in;
  aes_word_t sub_out;
  logic      load_acc;

  assign ready     = (state_q != SUB);
  assign out_valid = (state_q == DONE);
  assign data_out  = out_q;
  assign load_acc  = load && ready;

  // The first word bypasses the buffer so the load cycle already does useful work.
  assign sub_in = load_acc ? data_in[STATE_W-1 -: WORD_W] : buf_q[BUF_W-1 -: WORD_W];

  for (genvar i = 0; i < WORD_W / 8; i++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .din  (sub_in[8*i +: 8]),
      .dout (sub_out[8*i +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (load_acc) begin
          state_d = SUB;
          cnt_d   = CNT_W'(1);
          buf_d   = data_in[BUF_W-1:0];
          out_d   = {out_q[STATE_W-WORD_W-1:0], sub_out};
        end
      end
      SUB: begin
        buf_d = {buf_q[BUF_W-WORD_W-1:0], {WORD_W{1'b0}}};
        out_d = {out_q[STATE_W-WORD_W-1:0], sub_out};
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_inv_substitute.sv
// Directed and round-trip checks for the inverse SubBytes stage.
module tb_inv_substitute;

  logic         clk;
  logic         rst;
  logic         load;
  logic [127:0] data_in;
  logic         ready;
  logic         out_valid;
  logic [127:0] data_out;

  int checks;
  int errors;

  inv_substitute dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_in   (data_in),
    .ready     (ready),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] fwd_sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [127:0] VEC_IN  = 128'h637C777B_00000000_FFFFFFFF_16ED63ED;
  localparam logic [127:0] VEC_OUT = 128'h00010203_52525252_7D7D7D7D_FF530053;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents load for one edge (T0); returns 1 time unit after that edge.
  task automatic start(input logic [127:0] d);
    load    = 1'b1;
    data_in = d;
    tick();
    load    = 1'b0;
    data_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 128'h0) begin
      errors++;
      $display("FAIL reset_init: ready=%b valid=%b data=%h, want 1 0 0", ready, out_valid, data_out);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b valid=%b, want 1 0", ready, out_valid);
    end
  endtask

  task automatic test_single();
    start(VEC_IN);
    checks++;
    if (ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_t0: ready=%b valid=%b, want 0 0", ready, out_valid);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_t2_valid: got %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL single_t3: valid=%b ready=%b, want 1 1", out_valid, ready);
    end
    checks++;
    if (data_out !== VEC_OUT) begin
      errors++;
      $display("FAIL single_data: got %h want %h", data_out, VEC_OUT);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || data_out !== VEC_OUT) begin
      errors++;
      $display("FAIL single_hold: valid=%b data=%h want 1 %h", out_valid, data_out, VEC_OUT);
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] orig;
    logic [127:0] fwd;
    for (int n = 0; n < 100; n++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      for (int b = 0; b < 16; b++) fwd[8*b +: 8] = fwd_sbox[orig[8*b +: 8]];
      start(fwd);
      tick();
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b1 || data_out !== orig) begin
        errors++;
        $display("FAIL round_trip[%0d]: valid=%b data=%h want 1 %h", n, out_valid, data_out, orig);
      end
    end
  endtask

  task automatic test_load_ignored();
    start(VEC_IN);
    tick();
    load    = 1'b1;
    data_in = {128{1'b1}};
    tick();
    checks++;
    if (ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignored_t2: ready=%b valid=%b, want 0 0", ready, out_valid);
    end
    load    = 1'b0;
    data_in = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || data_out !== VEC_OUT) begin
      errors++;
      $display("FAIL ignored_data: valid=%b data=%h want 1 %h", out_valid, data_out, VEC_OUT);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL ignored_stay_done: valid=%b ready=%b want 1 1", out_valid, ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a_in  = 128'h00000000_63636363_7C7C7C7C_52525252;
    logic [127:0] a_out = 128'h52525252_00000000_01010101_48484848;
    logic [127:0] b_in  = 128'h16ED637C_FFFFFFFF_00000000_7B777C63;
    logic [127:0] b_out = 128'hFF530001_7D7D7D7D_52525252_03020100;
    start(a_in);
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || data_out !== a_out) begin
      errors++;
      $display("FAIL b2b_a: valid=%b data=%h want 1 %h", out_valid, data_out, a_out);
    end
    start(b_in);
    checks++;
    if (out_valid !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_valid_drop: valid=%b ready=%b want 0 0", out_valid, ready);
    end
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || data_out !== b_out) begin
      errors++;
      $display("FAIL b2b_b: valid=%b data=%h want 1 %h", out_valid, data_out, b_out);
    end
  endtask

  task automatic test_reset_mid();
    start({128{1'b1}});
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 128'h0) begin
      errors++;
      $display("FAIL rst_mid: ready=%b valid=%b data=%h want 1 0 0", ready, out_valid, data_out);
    end
    tick();
    rst = 1'b0;
    tick();
    start({16{8'h63}});
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || data_out !== 128'h0) begin
      errors++;
      $display("FAIL rst_mid_reload: valid=%b data=%h want 1 0", out_valid, data_out);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    load    = 1'b0;
    data_in = '0;
    rst     = 1'b0;
    test_reset();
    test_single();
    test_round_trip();
    test_load_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
